fp32_sqrt_arbiter: RTL and testbench
====================================

Name: fp32_sqrt_arbiter

Overview:
- Shares one combinational fp32_sqrt_lut instance among N_REQ requesters in the force pipeline.
- Round-robin arbitration, one operand accepted per cycle. The selected operand is registered into the LUT and the result is pipelined through PIPE_STAGES registers.
- Each result returns with the requester ID that issued it.
- Sits between the per-cell distance units and the shared sqrt datapath.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, 2, width of requester ID; must equal clog2(N_REQ)
PIPE_STAGES, 2, output register stages after the LUT (1..4)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global advance; low freezes the pipeline and grants nothing
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester accept; one-hot or zero
req_data  in  N_REQ*32  fp32 operands; requester i at bits [32i+31:32i]
sqrt_in  out  32  registered operand to the external LUT
sqrt_out  in  32  combinational result from the external LUT
rsp_valid  out  1  result valid
rsp_id  out  ID_W  requester that owns rsp_data
rsp_data  out  32  fp32 square root
busy  out  1  any valid in flight in stage 0..PIPE_STAGES

Behaviour:
- Reset values (async on rst_n low): req_ready=0, sqrt_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, RR pointer=N_REQ-1, all stage valids=0.
- Arbitration:
  - Combinational from req_valid, RR pointer and en.
  - Winner is the first requester with req_valid=1, searching from pointer+1 upward modulo N_REQ.
  - req_ready[winner]=1 only when en=1; all other bits 0.
  - A handshake is req_valid[i] & req_ready[i].
- RR pointer:
  - Loads the winner index on a handshake; otherwise holds.
  - Wrap: pointer N_REQ-1 searches from 0.
- Stage 0, on a handshake:
  - sqrt_in <= req_data[winner]; v0 <= 1; id0 <= winner.
  - With en=1 and no request: v0 <= 0; sqrt_in holds.
- Stages 1..PIPE_STAGES:
  - On en=1, stage k takes data/valid/id from stage k-1.
  - Stage 1 data is captured from sqrt_out.
  - The last stage drives rsp_valid/rsp_id/rsp_data.
- Latency: exactly 1+PIPE_STAGES enabled cycles from handshake edge to rsp_valid (3 at default).
- Throughput: 1 result per cycle while en=1.
- No output backpressure; rsp_valid is a one-cycle pulse per result, and requesters must always accept.
- en=0:
  - All registers hold, including rsp_valid; a held rsp_valid=1 is not a new result.
  - req_ready=0.
  - The pointer holds.
- Simultaneous requests: only one requester is served per cycle. The others keep req_valid high and their data stable until served.
- Fairness: with all requesters continuously valid, each is served exactly once per N_REQ handshakes.
- Reset mid-operation clears all in-flight results; no rsp_valid is produced for them.
- busy = OR of stage valids.
- Special operands (0, denormal, inf, NaN) pass to the LUT unchanged unless the optional feature is enabled.

Optional Feature:
- Macro FP32_SQRT_ARB_NEG_CHECK_EN.
- Defined:
  - Stage 0 records neg0 = sign bit of the accepted operand, excluding -0.0 (0x80000000). neg is pipelined alongside id.
  - At the output, neg forces rsp_data=0x7FC00000 (quiet NaN).
  - Adds output port rsp_err (1 bit, reset 0) = neg of the last stage.
- Not defined: no rsp_err port; sign bit is passed to the LUT unchanged.

Decomposition:
- Package fp32_sqrt_pkg holds:
  - FP32_W=32
  - FP32_QNAN=32'h7FC00000
  - FP32_NEG_ZERO=32'h80000000
  - typedef fp32_t (logic [31:0])
- Sub-module rr_arbiter (N parameter): takes req vector, pointer and en; outputs one-hot grant and winner index. Reusable for other shared units.
- Pipeline registers stay in the top module.

Test Plan:
- Single request, N_REQ=4: req_valid=4'b0010, req_data[1]=0x40800000 (4.0). Expect req_ready=4'b0010 for one cycle; rsp_valid 3 cycles later with rsp_id=1, rsp_data=0x40000000.
- All four requesters valid continuously with 0x41800000, 0x41100000, 0x40800000, 0x3F800000. Expect grants in order 0,1,2,3,0…; rsp_data sequence 0x40800000, 0x40400000, 0x40000000, 0x3F800000; one result per cycle.
- Pointer wrap: pointer=3, requests 4'b1001. Expect requester 0 granted, then requester 3.
- en held low 2 cycles with 2 results in flight: rsp_valid/rsp_data frozen, req_ready=0. Results resume in order after en=1, total latency extended by exactly 2.
- rst_n asserted asynchronously mid-cycle with 3 valid stages: all outputs go 0 immediately. After release, no stale rsp_valid; busy=0.
- With FP32_SQRT_ARB_NEG_CHECK_EN:
  - Operand 0xC0800000 (-4.0) -> rsp_data=0x7FC00000, rsp_err=1.
  - Operand 0x80000000 -> rsp_err=0.

Source files
------------

// File: rtl/fp32_sqrt_pkg.sv
// Shared fp32 constants and helpers for the square-root datapath.
package fp32_sqrt_pkg;

   localparam int          FP32_W        = 32;
   localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

   typedef logic [FP32_W-1:0] fp32_t;

   // Negative operand with no real root; -0.0 is excluded because sqrt(-0) = -0.
   function automatic logic fp32_is_neg(input fp32_t x);
      return x[FP32_W-1] && (x != FP32_NEG_ZERO);
   endfunction

endpackage

// File: rtl/fp32_sqrt_arbiter_rr.sv
// Round-robin arbiter: searches from ptr+1 upward (mod N) for the first request.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] winner
);

   always_comb begin
      logic          found;
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      winner = '0;
      grant  = '0;
      for (int k = 1; k <= N; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         idx = sum[IW-1:0];
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      if (found && en) begin
         grant[winner] = 1'b1;
      end
   end

endmodule

// File: rtl/fp32_sqrt_arbiter.sv
// Shares one external combinational fp32 sqrt LUT among N_REQ requesters.
// Optional negative-operand check: define FP32_SQRT_ARB_NEG_CHECK_EN.
module fp32_sqrt_arbiter
   import fp32_sqrt_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int PIPE_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [N_REQ*32-1:0] req_data,
   output fp32_t               sqrt_in,
   input  fp32_t               sqrt_out,
   output logic                rsp_valid,
   output logic [ID_W-1:0]     rsp_id,
   output fp32_t               rsp_data,
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
   output logic                rsp_err,
`endif
   output logic                busy
);

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  winner;
   logic             hs;

   logic [ID_W-1:0]        ptr_q, ptr_d;
   // Index 0 is the operand register feeding the LUT; 1..PIPE_STAGES carry results.
   logic [PIPE_STAGES:0]   v_q, v_d;
   logic [ID_W-1:0]        id_q  [0:PIPE_STAGES];
   logic [ID_W-1:0]        id_d  [0:PIPE_STAGES];
   fp32_t                  dat_q [0:PIPE_STAGES];
   fp32_t                  dat_d [0:PIPE_STAGES];
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
   logic [PIPE_STAGES:0]   neg_q, neg_d;
`endif

   // Gating with rst_n keeps req_ready low while reset is held.
   rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
      .req    (req_valid),
      .ptr    (ptr_q),
      .en     (en & rst_n),
      .grant  (grant),
      .winner (winner)
   );

   assign req_ready = grant;
   assign hs        = |(req_valid & grant);

   always_comb begin
      ptr_d = ptr_q;
      v_d   = v_q;
      id_d  = id_q;
      dat_d = dat_q;
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
      neg_d = neg_q;
`endif
      if (en) begin
         if (hs) begin
            ptr_d    = winner;
            v_d[0]   = 1'b1;
            id_d[0]  = winner;
            dat_d[0] = req_data[32*int'(winner) +: 32];
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
            neg_d[0] = fp32_is_neg(req_data[32*int'(winner) +: 32]);
`endif
         end else begin
            v_d[0] = 1'b0;
         end
         for (int k = 1; k <= PIPE_STAGES; k++) begin
            v_d[k]   = v_q[k-1];
            id_d[k]  = id_q[k-1];
            dat_d[k] = (k == 1) ? sqrt_out : dat_q[k-1];
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
            neg_d[k] = neg_q[k-1];
            if (k == 1 && neg_q[0]) begin
               dat_d[k] = FP32_QNAN;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= ID_W'(N_REQ-1);
         v_q   <= '0;
         for (int k = 0; k <= PIPE_STAGES; k++) begin
            id_q[k]  <= '0;
            dat_q[k] <= '0;
         end
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
         neg_q <= '0;
`endif
      end else begin
         ptr_q <= ptr_d;
         v_q   <= v_d;
         id_q  <= id_d;
         dat_q <= dat_d;
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
         neg_q <= neg_d;
`endif
      end
   end

   assign sqrt_in   = dat_q[0];
   assign rsp_valid = v_q[PIPE_STAGES];
   assign rsp_id    = id_q[PIPE_STAGES];
   assign rsp_data  = dat_q[PIPE_STAGES];
   assign busy      = |v_q;
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
   assign rsp_err   = neg_q[PIPE_STAGES];
`endif

endmodule

// File: tb/tb_fp32_sqrt_arbiter.sv
// Directed bench for fp32_sqrt_arbiter with a small sqrt LUT model on sqrt_in/sqrt_out.
module tb_fp32_sqrt_arbiter;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_data;
   logic [31:0]  sqrt_in;
   logic [31:0]  sqrt_out;
   logic         rsp_valid;
   logic [1:0]   rsp_id;
   logic [31:0]  rsp_data;
   logic         busy;
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
   logic         rsp_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   fp32_sqrt_arbiter #(.N_REQ(4), .ID_W(2), .PIPE_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .sqrt_in   (sqrt_in),
      .sqrt_out  (sqrt_out),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
      .rsp_err   (rsp_err),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed roots for the operands used below.
   always_comb begin
      case (sqrt_in)
         32'h4080_0000: sqrt_out = 32'h4000_0000;
         32'h4180_0000: sqrt_out = 32'h4080_0000;
         32'h4110_0000: sqrt_out = 32'h4040_0000;
         32'h3F80_0000: sqrt_out = 32'h3F80_0000;
         32'h8000_0000: sqrt_out = 32'h8000_0000;
         default:       sqrt_out = 32'h1234_5678;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %h", tag, got);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] all_ops  [0:3];
   logic [31:0] all_exp  [0:3];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      all_ops[0] = 32'h4180_0000; all_exp[0] = 32'h4080_0000;
      all_ops[1] = 32'h4110_0000; all_exp[1] = 32'h4040_0000;
      all_ops[2] = 32'h4080_0000; all_exp[2] = 32'h4000_0000;
      all_ops[3] = 32'h3F80_0000; all_exp[3] = 32'h3F80_0000;

      rst_n = 1'b0; en = 1'b0; req_valid = '0; req_data = '0;
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_sqrt_in",   sqrt_in, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data",  rsp_data, 32'h0);
      chk("rst_busy",      32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1;
      next_cycle();

      // Single request from requester 1.
      req_data[63:32] = 32'h4080_0000;
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t1_ready", 32'(req_ready), 32'h2);
      chk("t1_busy_idle", 32'(busy), 32'h0);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("t1_c1_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t1_c1_ready", 32'(req_ready), 32'h0);
      chk("t1_c1_busy", 32'(busy), 32'h1);
      chk("t1_c1_sqrt_in", sqrt_in, 32'h4080_0000);
      @(negedge clk);
      chk("t1_c2_rsp_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      chk("t1_c3_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_c3_rsp_id", 32'(rsp_id), 32'h1);
      chk("t1_c3_rsp_data", rsp_data, 32'h4000_0000);
      @(negedge clk);
      chk("t1_c4_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t1_c4_busy", 32'(busy), 32'h0);
      next_cycle();

      // Reset returns the pointer to N_REQ-1, then all four request continuously.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = all_ops[i];
      req_valid = 4'b1111;
      for (int j = 0; j < 11; j++) begin
         @(negedge clk);
         if (j < 8) chk($sformatf("t2_ready_%0d", j), 32'(req_ready), 32'(1 << (j % 4)));
         if (j >= 3) begin
            chk($sformatf("t2_rsp_valid_%0d", j), 32'(rsp_valid), 32'h1);
            chk($sformatf("t2_rsp_id_%0d", j), 32'(rsp_id), 32'((j - 3) % 4));
            chk($sformatf("t2_rsp_data_%0d", j), rsp_data, all_exp[(j - 3) % 4]);
         end
         next_cycle();
         if (j == 7) req_valid = '0;
      end
      @(negedge clk);
      chk("t2_drain_rsp_valid", 32'(rsp_valid), 32'h0);
      next_cycle();

      // Pointer is 3: requests on 0 and 3 -> 0 first, then 3.
      req_data[31:0]   = 32'h3F80_0000;
      req_data[127:96] = 32'h4180_0000;
      req_valid = 4'b1001;
      @(negedge clk);
      chk("t3_ready_c0", 32'(req_ready), 32'h1);
      next_cycle();
      @(negedge clk);
      chk("t3_ready_c1", 32'(req_ready), 32'h8);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("t3_c3_rsp_id", 32'(rsp_id), 32'h0);
      chk("t3_c3_rsp_data", rsp_data, 32'h3F80_0000);
      @(negedge clk);
      chk("t3_c4_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t3_c4_rsp_id", 32'(rsp_id), 32'h3);
      chk("t3_c4_rsp_data", rsp_data, 32'h4080_0000);
      next_cycle();

      // Two results in flight, then en low for two cycles.
      req_data[31:0]  = 32'h4080_0000;
      req_data[63:32] = 32'h4110_0000;
      req_valid = 4'b0001;
      @(negedge clk);
      chk("t4_ready_c0", 32'(req_ready), 32'h1);
      next_cycle();
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t4_ready_c1", 32'(req_ready), 32'h2);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("t4_c2_rsp_valid", 32'(rsp_valid), 32'h0);
      next_cycle();
      en = 1'b0;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t4_c3_ready_en0", 32'(req_ready), 32'h0);
      chk("t4_c3_rsp_id", 32'(rsp_id), 32'h0);
      chk("t4_c3_rsp_data", rsp_data, 32'h4000_0000);
      next_cycle();
      @(negedge clk);
      chk("t4_c4_ready_en0", 32'(req_ready), 32'h0);
      chk("t4_c4_rsp_valid_frozen", 32'(rsp_valid), 32'h1);
      chk("t4_c4_rsp_data_frozen", rsp_data, 32'h4000_0000);
      chk("t4_c4_busy", 32'(busy), 32'h1);
      next_cycle();
      en = 1'b1;
      req_valid = '0;
      @(negedge clk);
      chk("t4_c5_rsp_id_held", 32'(rsp_id), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("t4_c6_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t4_c6_rsp_id", 32'(rsp_id), 32'h1);
      chk("t4_c6_rsp_data", rsp_data, 32'h4040_0000);
      next_cycle();
      @(negedge clk);
      chk("t4_c7_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t4_c7_busy", 32'(busy), 32'h0);
      next_cycle();

      // Fill all three stages (pointer 1 -> grants 2,3,0), then async reset mid-cycle.
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = all_ops[i];
      req_valid = 4'b1111;
      next_cycle();
      next_cycle();
      next_cycle();
      chk("t5_pre_busy", 32'(busy), 32'h1);
      chk("t5_pre_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t5_pre_rsp_id", 32'(rsp_id), 32'h2);
      chk("t5_pre_rsp_data", rsp_data, 32'h4000_0000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", 32'(req_ready), 32'h0);
      chk("t5_rst_sqrt_in", sqrt_in, 32'h0);
      chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t5_rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("t5_rst_rsp_data", rsp_data, 32'h0);
      chk("t5_rst_busy", 32'(busy), 32'h0);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk($sformatf("t5_post_rsp_valid_%0d", j), 32'(rsp_valid), 32'h0);
         chk($sformatf("t5_post_busy_%0d", j), 32'(busy), 32'h0);
      end
      next_cycle();
      req_valid = 4'b1111;
      @(negedge clk);
      chk("t5_ptr_reset_ready", 32'(req_ready), 32'h1);
      next_cycle();
      req_valid = '0;
      for (int j = 0; j < 4; j++) next_cycle();

`ifdef FP32_SQRT_ARB_NEG_CHECK_EN
      // Negative operand -> quiet NaN and rsp_err; -0.0 passes as a normal result.
      req_data[63:32] = 32'hC080_0000;
      req_valid = 4'b0010;
      @(negedge clk);
      chk("neg_ready", 32'(req_ready), 32'h2);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("neg_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("neg_rsp_data", rsp_data, 32'h7FC0_0000);
      chk("neg_rsp_err", 32'(rsp_err), 32'h1);
      next_cycle();
      req_data[95:64] = 32'h8000_0000;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("negz_ready", 32'(req_ready), 32'h4);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("negz_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("negz_rsp_data", rsp_data, 32'h8000_0000);
      chk("negz_rsp_err", 32'(rsp_err), 32'h0);
      next_cycle();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
